pipe_pattern_xcvr: RTL and testbench

Parametrised pipe-integrity engine for host-link benchmarking. It combines a pattern generator that feeds a BTPipeOut endpoint with a pattern checker that consumes a BTPipeIn endpoint. It extends the single-width pipe checkers with a configurable data width, a multi-lane pattern set, independent in/out throttles, transfer counters and optional first-error capture. It sits between the endpoint instances and the wire-in/wire-out control registers in the top level.

---
 rtl/pipe_pattern_pkg.sv | 20 ++
 rtl/pipe_pattern_xcvr_if.sv | 24 ++
 rtl/pipe_pattern_gen.sv | 79 +++++++
 rtl/pipe_pattern_xcvr.sv | 149 ++++++++++++++
 tb/tb_pipe_pattern_xcvr.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pattern_pkg.sv
// Shared definitions for the pipe pattern transceiver.
//   - Pattern mode codes selected by the pattern input.
//   - LFSR tap mask and single-step function for x^32+x^22+x^2+x+1.
package pipe_pattern_pkg;

  localparam logic [2:0] PAT_COUNT = 3'd0;
  localparam logic [2:0] PAT_LFSR  = 3'd1;
  localparam logic [2:0] PAT_WALK  = 3'd2;
  localparam logic [2:0] PAT_FIXED = 3'd3;
  localparam logic [2:0] PAT_ALT   = 3'd4;

  // Fibonacci form, shifting left: bit 31 holds the oldest sequence bit, so
  // polynomial term x^j taps bit 31-j (x^0 -> 31, x^1 -> 30, x^2 -> 29, x^22 -> 9).
  localparam logic [31:0] LFSR_TAPS = 32'hE000_0200;

  function automatic logic [31:0] lfsr_step(input logic [31:0] state);
    return {state[30:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pipe_pattern_xcvr_if.sv
// Pipe endpoint bundle between the host endpoints and the pattern transceiver.
//   out_read/out_data/out_ready : BTPipeOut side (transceiver supplies words)
//   in_write/in_data/in_ready   : BTPipeIn side (transceiver consumes words)
// master = host endpoint side, slave = transceiver side.
interface pipe_pattern_xcvr_if #(
  parameter int unsigned DATA_W = 32
);
  logic              out_read;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              in_write;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output out_read, in_write, in_data,
    input  out_data, out_ready, in_ready
  );

  modport slave (
    input  out_read, in_write, in_data,
    output out_data, out_ready, in_ready
  );
endinterface

// File: rtl/pipe_pattern_gen.sv
// Pattern word source: word counter n, LFSR state at pattern index n*L, and the
// combinational L-lane word for the selected pattern.
//   clk, reset_n   : clock, async active-low reset
//   clear          : synchronous return to word 0 / LFSR_SEED (wins over advance)
//   advance        : step to the next word
//   pattern        : mode code, fixed_pattern : lane value for fixed/alternating
//   word           : current word, index : current word counter n
module pipe_pattern_gen
  import pipe_pattern_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [2:0]        pattern,
  input  logic [31:0]       fixed_pattern,
  output logic [DATA_W-1:0] word,
  output logic [31:0]       index
);

  localparam int unsigned Lanes = DATA_W / 32;

  logic [31:0] n_q, n_d;
  logic [31:0] lfsr_q, lfsr_d;

  // lfsr_chain[i] is the state for lane i; the last entry seeds the next word.
  logic [31:0] lfsr_chain [Lanes+1];

  assign lfsr_chain[0] = lfsr_q;

  for (genvar g = 0; g < Lanes; g++) begin : g_lane
    logic [31:0] k;
    logic [31:0] lane;

    assign lfsr_chain[g+1] = lfsr_step(lfsr_chain[g]);
    assign k = n_q * Lanes + 32'(g);

    always_comb begin
      lane = k;
      case (pattern)
        PAT_LFSR:  lane = lfsr_chain[g];
        PAT_WALK:  lane = 32'd1 << k[4:0];
        PAT_FIXED: lane = fixed_pattern;
        PAT_ALT:   lane = k[0] ? ~fixed_pattern : fixed_pattern;
        default:   lane = k;
      endcase
    end

    assign word[32*g +: 32] = lane;
  end

  always_comb begin
    n_d    = n_q;
    lfsr_d = lfsr_q;
    if (clear) begin
      n_d    = '0;
      lfsr_d = LFSR_SEED;
    end else if (advance) begin
      n_d    = n_q + 32'd1;
      lfsr_d = lfsr_chain[Lanes];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q    <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      n_q    <= n_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign index = n_q;

endmodule

// File: rtl/pipe_pattern_xcvr.sv
// Pipe-integrity engine: pattern generator for a pipe-out endpoint and pattern
// checker for a pipe-in endpoint, with throttles, transfer counters and an
// optional first-error record (built when PIPE_PATTERN_ERR_CAPTURE_EN is defined).
//   clk, reset_n          : clock, async active-low reset
//   cfg_reset             : sync clear of stream state (not throttles); strobes ignored
//   pattern/fixed_pattern : pattern selection, change only under cfg_reset
//   throttle_set/_in_val/_out_val : load both throttle rotators
//   pipe (slave)          : pipe-out / pipe-in strobes, data, ready
//   error_count           : saturating mismatch count
//   in_words/out_words    : words consumed / supplied (wrap)
//   err_valid/err_index/err_expected/err_actual : first-mismatch record
module pipe_pattern_xcvr
  import pipe_pattern_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_reset,
  input  logic [2:0]         pattern,
  input  logic [31:0]        fixed_pattern,
  input  logic               throttle_set,
  input  logic [31:0]        throttle_in_val,
  input  logic [31:0]        throttle_out_val,
  pipe_pattern_xcvr_if.slave pipe,
  output logic [31:0]        error_count,
  output logic [31:0]        in_words,
  output logic [31:0]        out_words,
  output logic               err_valid,
  output logic [31:0]        err_index,
  output logic [DATA_W-1:0]  err_expected,
  output logic [DATA_W-1:0]  err_actual
);

  logic              gen_advance;
  logic              chk_advance;
  logic [DATA_W-1:0] exp_word;
  logic              mismatch;
  logic [31:0]       err_cnt_q, err_cnt_d;
  logic [31:0]       thr_in_q, thr_in_d;
  logic [31:0]       thr_out_q, thr_out_d;

  assign gen_advance = pipe.out_read & ~cfg_reset;
  assign chk_advance = pipe.in_write & ~cfg_reset;

  // The word counters double as the transfer counts: both step on the same
  // strobe, clear on the same events and wrap at 2^32.
  pipe_pattern_gen #(
    .DATA_W    (DATA_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_gen (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (cfg_reset),
    .advance       (gen_advance),
    .pattern       (pattern),
    .fixed_pattern (fixed_pattern),
    .word          (pipe.out_data),
    .index         (out_words)
  );

  pipe_pattern_gen #(
    .DATA_W    (DATA_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_chk (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (cfg_reset),
    .advance       (chk_advance),
    .pattern       (pattern),
    .fixed_pattern (fixed_pattern),
    .word          (exp_word),
    .index         (in_words)
  );

  assign mismatch = chk_advance & (pipe.in_data != exp_word);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cfg_reset) begin
      err_cnt_d = '0;
    end else if (mismatch && (err_cnt_q != 32'hFFFF_FFFF)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_comb begin
    thr_in_d  = {thr_in_q[0], thr_in_q[31:1]};
    thr_out_d = {thr_out_q[0], thr_out_q[31:1]};
    if (throttle_set) begin
      thr_in_d  = throttle_in_val;
      thr_out_d = throttle_out_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
      thr_in_q  <= 32'hFFFF_FFFF;
      thr_out_q <= 32'hFFFF_FFFF;
    end else begin
      err_cnt_q <= err_cnt_d;
      thr_in_q  <= thr_in_d;
      thr_out_q <= thr_out_d;
    end
  end

  assign error_count    = err_cnt_q;
  assign pipe.in_ready  = thr_in_q[0];
  assign pipe.out_ready = thr_out_q[0];

`ifdef PIPE_PATTERN_ERR_CAPTURE_EN
  logic              err_valid_q;
  logic [31:0]       err_index_q;
  logic [DATA_W-1:0] err_expected_q;
  logic [DATA_W-1:0] err_actual_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_valid_q    <= 1'b0;
      err_index_q    <= '0;
      err_expected_q <= '0;
      err_actual_q   <= '0;
    end else if (cfg_reset) begin
      err_valid_q    <= 1'b0;
      err_index_q    <= '0;
      err_expected_q <= '0;
      err_actual_q   <= '0;
    end else if (mismatch && !err_valid_q) begin
      err_valid_q    <= 1'b1;
      err_index_q    <= in_words;
      err_expected_q <= exp_word;
      err_actual_q   <= pipe.in_data;
    end
  end

  assign err_valid    = err_valid_q;
  assign err_index    = err_index_q;
  assign err_expected = err_expected_q;
  assign err_actual   = err_actual_q;
`else
  assign err_valid    = 1'b0;
  assign err_index    = '0;
  assign err_expected = '0;
  assign err_actual   = '0;
`endif

endmodule

// File: tb/tb_pipe_pattern_xcvr.sv
// Directed bench for pipe_pattern_xcvr: a 32-bit instance for most checks and
// a 64-bit instance for the multi-lane count pattern.
module tb_pipe_pattern_xcvr;
  import pipe_pattern_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_reset;
  logic [2:0]  pattern;
  logic [31:0] fixed_pattern;
  logic        throttle_set;
  logic [31:0] throttle_in_val;
  logic [31:0] throttle_out_val;

  pipe_pattern_xcvr_if #(.DATA_W(32)) p32 ();
  pipe_pattern_xcvr_if #(.DATA_W(64)) p64 ();

  logic [31:0] error_count, in_words, out_words, err_index;
  logic        err_valid;
  logic [31:0] err_expected, err_actual;

  logic [31:0] error_count64, in_words64, out_words64, err_index64;
  logic        err_valid64;
  logic [63:0] err_expected64, err_actual64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_pattern_xcvr #(.DATA_W(32), .LFSR_SEED(32'h0000_0001)) u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_reset        (cfg_reset),
    .pattern          (pattern),
    .fixed_pattern    (fixed_pattern),
    .throttle_set     (throttle_set),
    .throttle_in_val  (throttle_in_val),
    .throttle_out_val (throttle_out_val),
    .pipe             (p32.slave),
    .error_count      (error_count),
    .in_words         (in_words),
    .out_words        (out_words),
    .err_valid        (err_valid),
    .err_index        (err_index),
    .err_expected     (err_expected),
    .err_actual       (err_actual)
  );

  pipe_pattern_xcvr #(.DATA_W(64), .LFSR_SEED(32'h0000_0001)) u_dut64 (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_reset        (cfg_reset),
    .pattern          (pattern),
    .fixed_pattern    (fixed_pattern),
    .throttle_set     (throttle_set),
    .throttle_in_val  (throttle_in_val),
    .throttle_out_val (throttle_out_val),
    .pipe             (p64.slave),
    .error_count      (error_count64),
    .in_words         (in_words64),
    .out_words        (out_words64),
    .err_valid        (err_valid64),
    .err_index        (err_index64),
    .err_expected     (err_expected64),
    .err_actual       (err_actual64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream_reset(input logic [2:0] pat, input logic [31:0] fix);
    pattern       = pat;
    fixed_pattern = fix;
    cfg_reset     = 1'b1;
    tick();
    cfg_reset     = 1'b0;
  endtask

  // Independent reference: taps written out bit by bit.
  function automatic logic [31:0] model_lfsr(input logic [31:0] seed, input int steps);
    logic [31:0] s;
    logic        fb;
    s = seed;
    for (int i = 0; i < steps; i++) begin
      fb = s[31] ^ s[30] ^ s[29] ^ s[9];
      s  = {s[30:0], fb};
    end
    return s;
  endfunction

  typedef struct {
    logic [2:0]  pat;
    logic [31:0] fix;
    int          skip;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] cap_exp_valid;
    logic [31:0] cap_exp_index;
    logic [31:0] cap_exp_expected;

    vecs[0]  = '{PAT_COUNT, 32'h0,          0,  32'h0000_0000};
    vecs[1]  = '{PAT_COUNT, 32'h0,          5,  32'h0000_0005};
    vecs[2]  = '{PAT_LFSR,  32'h0,          0,  32'h0000_0001};
    vecs[3]  = '{PAT_LFSR,  32'h0,          1,  32'h0000_0002};
    vecs[4]  = '{PAT_LFSR,  32'h0,          2,  32'h0000_0004};
    vecs[5]  = '{PAT_LFSR,  32'h0,          10, 32'h0000_0401};
    vecs[6]  = '{PAT_LFSR,  32'h0,          11, 32'h0000_0802};
    vecs[7]  = '{PAT_WALK,  32'h0,          3,  32'h0000_0008};
    vecs[8]  = '{PAT_WALK,  32'h0,          33, 32'h0000_0002};
    vecs[9]  = '{PAT_FIXED, 32'hA5A5_5A5A,  2,  32'hA5A5_5A5A};
    vecs[10] = '{PAT_ALT,   32'h1234_5678,  3,  32'hEDCB_A987};
    vecs[11] = '{3'd5,      32'h0,          7,  32'h0000_0007};
    vecs[12] = '{3'd7,      32'hFFFF_FFFF,  0,  32'h0000_0000};

    reset_n          = 1'b0;
    cfg_reset        = 1'b0;
    pattern          = PAT_COUNT;
    fixed_pattern    = 32'h0;
    throttle_set     = 1'b0;
    throttle_in_val  = 32'h0;
    throttle_out_val = 32'h0;
    p32.out_read = 1'b0; p32.in_write = 1'b0; p32.in_data = '0;
    p64.out_read = 1'b0; p64.in_write = 1'b0; p64.in_data = '0;

    tick();
    tick();
    check("rst_out_data",  64'(p32.out_data), 64'h0);
    check("rst_out_ready", 64'(p32.out_ready), 64'h1);
    check("rst_in_ready",  64'(p32.in_ready), 64'h1);
    check("rst_err_count", 64'(error_count), 64'h0);
    check("rst_err_valid", 64'(err_valid), 64'h0);
    reset_n = 1'b1;
    tick();

    // 64-bit count pattern: two lanes per word.
    check("w64_word0", p64.out_data, 64'h00000001_00000000);
    p64.out_read = 1'b1;
    tick();
    check("w64_word1", p64.out_data, 64'h00000003_00000002);
    tick();
    check("w64_word2", p64.out_data, 64'h00000005_00000004);
    tick();
    check("w64_word3", p64.out_data, 64'h00000007_00000006);
    tick();
    p64.out_read = 1'b0;
    check("w64_word4", p64.out_data, 64'h00000009_00000008);
    check("w64_out_words", 64'(out_words64), 64'd4);

    // Table-driven pattern vectors.
    foreach (vecs[v]) begin
      stream_reset(vecs[v].pat, vecs[v].fix);
      p32.out_read = 1'b1;
      repeat (vecs[v].skip) tick();
      p32.out_read = 1'b0;
      check($sformatf("vec%0d_data", v), 64'(p32.out_data), 64'(vecs[v].exp));
      check($sformatf("vec%0d_words", v), 64'(out_words), 64'(vecs[v].skip));
    end

    // LFSR loopback, 1024 words.
    stream_reset(PAT_LFSR, 32'h0);
    p32.out_read = 1'b1;
    p32.in_write = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      p32.in_data = p32.out_data;
      tick();
    end
    p32.out_read = 1'b0;
    p32.in_write = 1'b0;
    check("loop_err_count", 64'(error_count), 64'h0);
    check("loop_in_words", 64'(in_words), 64'd1024);
    check("loop_out_words", 64'(out_words), 64'd1024);
    check("loop_word1024", 64'(p32.out_data), 64'(model_lfsr(32'h1, 1024)));

    // Fixed pattern with one corrupted word at index 2.
    stream_reset(PAT_FIXED, 32'hA5A5_5A5A);
    p32.in_write = 1'b1;
    for (int w = 0; w < 5; w++) begin
      p32.in_data = (w == 2) ? 32'h0 : 32'hA5A5_5A5A;
      tick();
    end
    p32.in_write = 1'b0;
`ifdef PIPE_PATTERN_ERR_CAPTURE_EN
    cap_exp_valid    = 32'd1;
    cap_exp_index    = 32'd2;
    cap_exp_expected = 32'hA5A5_5A5A;
`else
    cap_exp_valid    = 32'd0;
    cap_exp_index    = 32'd0;
    cap_exp_expected = 32'd0;
`endif
    check("cap_err_count", 64'(error_count), 64'd1);
    check("cap_in_words", 64'(in_words), 64'd5);
    check("cap_valid", 64'(err_valid), 64'(cap_exp_valid));
    check("cap_index", 64'(err_index), 64'(cap_exp_index));
    check("cap_expected", 64'(err_expected), 64'(cap_exp_expected));
    check("cap_actual", 64'(err_actual), 64'h0);
    // A second mismatch counts but keeps the first record.
    p32.in_write = 1'b1;
    p32.in_data  = 32'hFFFF_FFFF;
    tick();
    p32.in_write = 1'b0;
    check("cap2_err_count", 64'(error_count), 64'd2);
    check("cap2_index", 64'(err_index), 64'(cap_exp_index));
    check("cap2_actual", 64'(err_actual), 64'h0);

    // Throttle rotation.
    throttle_in_val  = 32'h0000_0005;
    throttle_out_val = 32'h8000_0003;
    throttle_set     = 1'b1;
    tick();
    throttle_set     = 1'b0;
    for (int c = 0; c < 40; c++) begin
      check($sformatf("thr_in_c%0d", c), 64'(p32.in_ready), 64'(throttle_in_val[c % 32]));
      check($sformatf("thr_out_c%0d", c), 64'(p32.out_ready), 64'(throttle_out_val[c % 32]));
      tick();
    end

    // cfg_reset mid-stream with strobes active.
    stream_reset(PAT_LFSR, 32'h0);
    p32.out_read = 1'b1;
    p32.in_write = 1'b1;
    for (int i = 0; i < 7; i++) begin
      p32.in_data = (i == 4) ? (p32.out_data ^ 32'h1) : p32.out_data;
      tick();
    end
    check("mid_err_count_pre", 64'(error_count), 64'd1);
    check("mid_out_words_pre", 64'(out_words), 64'd7);
    p32.in_data = 32'h0;
    cfg_reset   = 1'b1;
    tick();
    cfg_reset    = 1'b0;
    p32.out_read = 1'b0;
    p32.in_write = 1'b0;
    check("mid_in_words", 64'(in_words), 64'd0);
    check("mid_out_words", 64'(out_words), 64'd0);
    check("mid_err_count", 64'(error_count), 64'd0);
    check("mid_err_valid", 64'(err_valid), 64'd0);
    check("mid_out_data", 64'(p32.out_data), 64'h1);
    p32.in_write = 1'b1;
    p32.in_data  = 32'h0000_0001;
    tick();
    p32.in_write = 1'b0;
    check("mid_chk_seed_err", 64'(error_count), 64'd0);
    check("mid_chk_in_words", 64'(in_words), 64'd1);

    // Asynchronous reset between edges.
    throttle_in_val  = 32'h0;
    throttle_out_val = 32'h0;
    throttle_set     = 1'b1;
    tick();
    throttle_set     = 1'b0;
    stream_reset(PAT_COUNT, 32'h0);
    p32.out_read = 1'b1;
    repeat (3) tick();
    p32.out_read = 1'b0;
    p32.in_write = 1'b1;
    p32.in_data  = 32'hDEAD_BEEF;
    tick();
    p32.in_write = 1'b0;
    check("arst_pre_in_ready", 64'(p32.in_ready), 64'h0);
    check("arst_pre_err", 64'(error_count), 64'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_data", 64'(p32.out_data), 64'h0);
    check("arst_out_words", 64'(out_words), 64'h0);
    check("arst_in_words", 64'(in_words), 64'h0);
    check("arst_err_count", 64'(error_count), 64'h0);
    check("arst_in_ready", 64'(p32.in_ready), 64'h1);
    check("arst_out_ready", 64'(p32.out_ready), 64'h1);
    check("arst_thr_in", 64'(u_dut.thr_in_q), 64'hFFFF_FFFF);
    check("arst_thr_out", 64'(u_dut.thr_out_q), 64'hFFFF_FFFF);
    tick();
    reset_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
